// File: rtl/dcc_bus_arbiter.sv
// dcc_bus_arbiter: release/grant/return sequencer for the shared SH-2 bus.
// Optional BGR_N watchdog: define DCC_ARB_WATCHDOG_EN.
module dcc_bus_arbiter #(
    parameter int unsigned TURN_CYC = 1,
    parameter int unsigned WD_LIMIT = 255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE_R,
    input  logic       BGR_N,
    input  logic       BREQ_N,
    input  logic       EXBREQ_N,
    output logic       BRLS_N,
    output logic       BACK_N,
    output logic       EXBACK_N,
    output logic [1:0] OWNER,
    output logic       ARB_ERR
);

    typedef enum logic [2:0] {
        S_MOWN,
        S_REQ,
        S_GRANT,
        S_TURN,
        S_RET
    } state_t;

    localparam logic [7:0] TURN_LD = 8'(TURN_CYC);
    localparam logic [1:0] P_SLV   = 2'd1;
    localparam logic [1:0] P_EXT   = 2'd2;

    state_t     state_q, state_d;
    logic [1:0] pend_q, pend_d;
    logic [7:0] cnt_q, cnt_d;
    logic       pend_rel;

`ifdef DCC_ARB_WATCHDOG_EN
    localparam logic [7:0] WD_LIM = 8'(WD_LIMIT);
    logic [7:0] wd_q, wd_d;
    logic       err_q, err_d;
`else
    logic unused_wd_limit;
    assign unused_wd_limit = ^(8'(WD_LIMIT));
`endif

    // Next-state: request latch, grant hand-off, dead-time and return
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        pend_rel = (pend_q == P_EXT) ? EXBREQ_N : BREQ_N;
        unique case (state_q)
            S_MOWN: begin
                if (!EXBREQ_N) begin
                    state_d = S_REQ;
                    pend_d  = P_EXT;
                end else if (!BREQ_N) begin
                    state_d = S_REQ;
                    pend_d  = P_SLV;
                end
            end
            S_REQ: begin
                if (!BGR_N) begin
                    state_d = S_GRANT;
                end else if (pend_rel) begin
                    state_d = S_MOWN;
                end
            end
            S_GRANT: begin
                if (pend_rel) begin
                    state_d = S_TURN;
                    cnt_d   = TURN_LD;
                end
            end
            S_TURN: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (!EXBREQ_N) begin
                    state_d = S_GRANT;
                    pend_d  = P_EXT;
                end else if (!BREQ_N) begin
                    state_d = S_GRANT;
                    pend_d  = P_SLV;
                end else begin
                    state_d = S_RET;
                end
            end
            S_RET: begin
                if (BGR_N) begin
                    state_d = S_MOWN;
                end
            end
            default: state_d = S_MOWN;
        endcase
`ifdef DCC_ARB_WATCHDOG_EN
        err_d = err_q;
        wd_d  = (state_d != state_q) ? 8'd0 : wd_q;
        if ((state_q == S_REQ || state_q == S_RET) &&
            state_d == state_q) begin
            if (wd_q == WD_LIM - 8'd1) begin
                state_d = S_MOWN;
                err_d   = 1'b1;
                wd_d    = 8'd0;
            end else begin
                wd_d = wd_q + 8'd1;
            end
        end
`endif
    end

    // State register: sync reset, advance only on CE_R
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_MOWN;
            pend_q  <= 2'd0;
            cnt_q   <= 8'd0;
`ifdef DCC_ARB_WATCHDOG_EN
            wd_q    <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else if (CE_R) begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
`ifdef DCC_ARB_WATCHDOG_EN
            wd_q    <= wd_d;
            err_q   <= err_d;
`endif
        end
    end

    // Output decode from registered state and latched winner only
    always_comb begin
        BRLS_N   = !(state_q == S_REQ || state_q == S_GRANT ||
                     state_q == S_TURN);
        BACK_N   = !(state_q == S_GRANT && pend_q == P_SLV);
        EXBACK_N = !(state_q == S_GRANT && pend_q == P_EXT);
        OWNER    = 2'd3;
        if (state_q == S_MOWN) begin
            OWNER = 2'd0;
        end else if (state_q == S_GRANT) begin
            OWNER = pend_q;
        end
    end

`ifdef DCC_ARB_WATCHDOG_EN
    assign ARB_ERR = err_q;
`else
    assign ARB_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_dcc_bus_arbiter.sv
// tb_dcc_bus_arbiter: directed scenarios plus random traffic
// checked against an owner-level model of the bus hand-off.
module tb_dcc_bus_arbiter;

    localparam int TURN = 1;
    localparam int WDL  = 4;

    logic       clk = 1'b0;
    logic       rst, ce_r, bgr_n, breq_n, exbreq_n;
    logic       brls_n, back_n, exback_n, arb_err;
    logic [1:0] owner;

    int checks = 0;
    int errors = 0;

    // model: who holds the bus, whether master is asked to let go,
    // remaining dead time (-1 when not between owners)
    logic m_brls;
    int   m_owner;
    int   m_pend;
    int   m_dead;
    int   m_wd;
    logic m_err;

    dcc_bus_arbiter #(
        .TURN_CYC(TURN),
        .WD_LIMIT(WDL)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .CE_R(ce_r),
        .BGR_N(bgr_n),
        .BREQ_N(breq_n),
        .EXBREQ_N(exbreq_n),
        .BRLS_N(brls_n),
        .BACK_N(back_n),
        .EXBACK_N(exback_n),
        .OWNER(owner),
        .ARB_ERR(arb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    task automatic m_idle();
        m_brls  = 1'b1;
        m_owner = 0;
        m_dead  = -1;
        m_wd    = 0;
    endtask

    task automatic m_give(input int who);
        m_brls  = 1'b0;
        m_owner = who;
        m_pend  = who;
        m_dead  = -1;
        m_wd    = 0;
    endtask

    task automatic m_wait_tick();
`ifdef DCC_ARB_WATCHDOG_EN
        m_wd++;
        if (m_wd == WDL) begin
            m_idle();
            m_err = 1'b1;
        end
`endif
    endtask

    // one clock edge of the model, using the inputs being driven
    task automatic model_step();
        logic idle, waitg, turn, ret, held, rel;
        if (rst) begin
            m_idle();
            m_pend = 0;
            m_err  = 1'b0;
            return;
        end
        if (!ce_r) return;
        idle  = m_brls && m_owner == 0;
        ret   = m_brls && m_owner == 3;
        waitg = !m_brls && m_owner == 3 && m_dead < 0;
        turn  = !m_brls && m_owner == 3 && m_dead >= 0;
        held  = m_owner == 1 || m_owner == 2;
        rel   = (m_pend == 2) ? exbreq_n : breq_n;
        if (idle) begin
            if (!exbreq_n || !breq_n) begin
                m_brls  = 1'b0;
                m_owner = 3;
                m_pend  = !exbreq_n ? 2 : 1;
                m_wd    = 0;
            end
        end else if (waitg) begin
            if (!bgr_n) m_give(m_pend);
            else if (rel) m_idle();
            else m_wait_tick();
        end else if (held) begin
            if (rel) begin
                m_owner = 3;
                m_dead  = TURN;
            end
        end else if (turn) begin
            if (m_dead > 0) m_dead--;
            else if (!exbreq_n) m_give(2);
            else if (!breq_n) m_give(1);
            else begin
                m_brls = 1'b1;
                m_dead = -1;
                m_wd   = 0;
            end
        end else if (ret) begin
            if (bgr_n) m_idle();
            else m_wait_tick();
        end
    endtask

    task automatic cyc(input logic r, input logic ce, input logic bgr,
                       input logic breq, input logic exreq);
        rst      = r;
        ce_r     = ce;
        bgr_n    = bgr;
        breq_n   = breq;
        exbreq_n = exreq;
        model_step();
        @(negedge clk);
        check("brls_n", 8'(brls_n), 8'(m_brls));
        check("back_n", 8'(back_n), 8'(m_owner != 1));
        check("exback_n", 8'(exback_n), 8'(m_owner != 2));
        check("owner", 8'(owner), 8'(m_owner));
        check("arb_err", 8'(arb_err), 8'(m_err));
        check("ack_excl", 8'(back_n | exback_n), 8'd1);
    endtask

    initial begin
        logic rq, xrq, bg;
        m_idle();
        m_pend = 0;
        m_err  = 1'b0;

        // reset with both requests low
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        check("rst_out", 8'({brls_n, back_n, exback_n}), 8'b111);
        check("rst_own", 8'(owner), 8'd0);
        check("rst_err", 8'(arb_err), 8'd0);
        // simultaneous requests: external wins
        cyc(0, 1, 1, 0, 0);
        check("req_brls", 8'(brls_n), 8'd0);
        cyc(0, 1, 0, 0, 0);
        check("ext_first", 8'({back_n, exback_n}), 8'b10);
        check("ext_own", 8'(owner), 8'd2);
        // external drops: dead time then slave, BRLS_N stays low
        cyc(0, 1, 0, 0, 1);
        check("ext_rel", 8'({brls_n, exback_n}), 8'b01);
        cyc(0, 1, 0, 0, 1);
        check("dead_brls", 8'({brls_n, back_n}), 8'b01);
        cyc(0, 1, 0, 0, 1);
        check("slv_grant", 8'({brls_n, back_n}), 8'b00);
        check("slv_own", 8'(owner), 8'd1);
        // CE_R low, slave request toggling: nothing moves
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1'(i & 1), 1);
            check("ce_hold", 8'({back_n, owner}), 8'b001);
        end
        // slave drops, dead time, return
        cyc(0, 1, 0, 1, 1);
        check("slv_rel", 8'(back_n), 8'd1);
        cyc(0, 1, 0, 1, 1);
        cyc(0, 1, 0, 1, 1);
        check("ret_brls", 8'(brls_n), 8'd1);
        cyc(0, 1, 1, 1, 1);
        check("mown", 8'(owner), 8'd0);
        // withdraw inside REQ
        cyc(0, 1, 1, 0, 1);
        check("wd_req", 8'(brls_n), 8'd0);
        cyc(0, 1, 1, 1, 1);
        check("withdraw", 8'({brls_n, back_n, exback_n}), 8'b111);
        cyc(0, 1, 1, 1, 1);
`ifdef DCC_ARB_WATCHDOG_EN
        // BGR_N stuck high: watchdog fires after WDL cycles
        for (int i = 0; i <= WDL; i++) cyc(0, 1, 1, 0, 1);
        check("wdog_err", 8'(arb_err), 8'd1);
        cyc(0, 1, 1, 1, 1);
        cyc(0, 1, 1, 1, 1);
        check("wdog_sticky", 8'(arb_err), 8'd1);
`endif
        cyc(1, 1, 1, 1, 1);

        // random traffic
        rq  = 1'b1;
        xrq = 1'b1;
        bg  = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(7) == 0) rq = ~rq;
            if ($urandom_range(9) == 0) xrq = ~xrq;
            if ($urandom_range(3) != 0) bg = m_brls;
            else if ($urandom_range(3) == 0) bg = 1'($urandom);
            cyc(1'($urandom_range(299) == 0),
                1'($urandom_range(6) != 0), bg, rq, xrq);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
